// File: rtl/memory_access_stage.sv
// RV32I memory-access stage: data-cache handshake, load formatting
// and the MA/WB pipeline register (also the EX forwarding source).
package rv32i_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;

endpackage

module memory_access_stage
  import rv32i_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  rv32i_control_word      ctrl_word_in,
  input  logic [31:0]            instruction_in,
  input  logic [31:0]            PC_in,
  input  logic [31:0]            alu_out_in,
  input  logic [31:0]            rs2_in,
  input  logic [3:0]             mem_byte_enable_in,
  input  logic                   br_en_in,
  input  logic                   IF_stall,
  output logic                   data_read,
  output logic                   data_write,
  output logic [31:0]            data_addr,
  output logic [31:0]            data_wdata,
  output logic [3:0]             data_mbe,
  input  logic [31:0]            data_rdata,
  input  logic                   data_resp,
  output logic                   MA_stall,
  output rv32i_control_word      ctrl_word_out,
  output logic [31:0]            instruction_out,
  output logic [31:0]            PC_out,
  output logic [31:0]            wb_data_out,
  output logic                   br_en_out,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {REQ, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] hold_rdata;
  logic        is_load, is_store, mem_op;
  logic        latch_hold;
  logic [31:0] rdata, sh, ld_data, wb_data;
  logic [2:0]  funct3;
  logic        advance;

  assign is_load  = ctrl_word_in.opcode == op_load;
  assign is_store = ctrl_word_in.opcode == op_store;
  assign mem_op   = is_load || is_store;
  assign funct3   = instruction_in[14:12];

  assign data_addr  = {alu_out_in[31:2], 2'b00};
  assign data_wdata = rs2_in << {alu_out_in[1:0], 3'b000};

  always_comb begin
    state_nx   = state;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_mbe   = 4'b0000;
    MA_stall   = 1'b0;
    latch_hold = 1'b0;
    unique case (state)
      REQ: begin
        data_read  = is_load;
        data_write = is_store;
        data_mbe   = is_store ? mem_byte_enable_in : 4'b0000;
        MA_stall   = mem_op && !data_resp;
        if (mem_op && data_resp && IF_stall) begin
          latch_hold = 1'b1;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (!IF_stall) state_nx = REQ;
      end
      default: state_nx = REQ;
    endcase
    // Nothing reaches the cache while the stage is held in reset.
    if (!rst) begin
      data_read  = 1'b0;
      data_write = 1'b0;
      data_mbe   = 4'b0000;
      MA_stall   = 1'b0;
    end
  end

  assign rdata = (state == HOLD) ? hold_rdata : data_rdata;
  assign sh    = rdata >> {alu_out_in[1:0], 3'b000};

  always_comb begin
    ld_data = sh;
    case (funct3)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  assign wb_data = is_load ? ld_data : alu_out_in;
  assign advance = !MA_stall && !IF_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= REQ;
      hold_rdata <= '0;
    end else begin
      state <= state_nx;
      if (latch_hold) hold_rdata <= data_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_word_out   <= '0;
      instruction_out <= '0;
      PC_out          <= '0;
      wb_data_out     <= '0;
      br_en_out       <= 1'b0;
    end else if (advance) begin
      ctrl_word_out   <= ctrl_word_in;
      instruction_out <= instruction_in;
      PC_out          <= PC_in;
      wb_data_out     <= wb_data;
      br_en_out       <= br_en_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (MA_stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, hold
// under IF_stall, non-memory ops and asynchronous reset.
module tb_memory_access_stage;
  import rv32i_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  rv32i_control_word ctrl_word_in;
  logic [31:0]       instruction_in, PC_in, alu_out_in, rs2_in;
  logic [3:0]        mem_byte_enable_in;
  logic              br_en_in, IF_stall;
  logic              data_read, data_write;
  logic [31:0]       data_addr, data_wdata;
  logic [3:0]        data_mbe;
  logic [31:0]       data_rdata;
  logic              data_resp, MA_stall;
  rv32i_control_word ctrl_word_out;
  logic [31:0]       instruction_out, PC_out, wb_data_out;
  logic              br_en_out;
  logic [15:0]       stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ctrl_word_in(ctrl_word_in),
    .instruction_in(instruction_in),
    .PC_in(PC_in), .alu_out_in(alu_out_in),
    .rs2_in(rs2_in),
    .mem_byte_enable_in(mem_byte_enable_in),
    .br_en_in(br_en_in), .IF_stall(IF_stall),
    .data_read(data_read), .data_write(data_write),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_mbe(data_mbe), .data_rdata(data_rdata),
    .data_resp(data_resp), .MA_stall(MA_stall),
    .ctrl_word_out(ctrl_word_out),
    .instruction_out(instruction_out),
    .PC_out(PC_out), .wb_data_out(wb_data_out),
    .br_en_out(br_en_out), .stall_cycles(stall_cycles)
  );

  function automatic logic [31:0] ins(
    input logic [2:0] f3, input rv32i_opcode op);
    return {17'd0, f3, 5'd1, op};
  endfunction

  task automatic set_op(input rv32i_opcode op,
                        input logic [2:0] f3,
                        input logic [31:0] addr);
    ctrl_word_in        = '0;
    ctrl_word_in.opcode = op;
    ctrl_word_in.rd     = 5'd1;
    instruction_in      = ins(f3, op);
    alu_out_in          = addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_op(op_imm, 3'b000, 32'h0);
    PC_in = 0; rs2_in = 0; mem_byte_enable_in = 0;
    br_en_in = 0; IF_stall = 0;
    data_rdata = 0; data_resp = 0;
    step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if (wb_data_out !== 32'h0 || PC_out !== 32'h0 ||
        stall_cycles !== 16'h0 || ctrl_word_out !== '0) begin
      errors++;
      $display("FAIL reset_regs wb=%h pc=%h sc=%0d", wb_data_out,
               PC_out, stall_cycles);
    end
  endtask

  task automatic test_load_wait();
    step();
    set_op(op_load, 3'b000, 32'h0000_1003);
    data_rdata = 32'h80FF_FF12;
    data_resp  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_read !== 1'b1 || MA_stall !== 1'b1 ||
          data_addr !== 32'h0000_1000) begin
        errors++;
        $display("FAIL lb_wait%0d rd=%b st=%b addr=%h want 1 1 1000",
                 i, data_read, MA_stall, data_addr);
      end
      step();
    end
    data_resp = 1'b1;
    #1;
    checks++;
    if (MA_stall !== 1'b0) begin
      errors++;
      $display("FAIL lb_resp_stall got %b want 0", MA_stall);
    end
    step();
    checks++;
    if (wb_data_out !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_data got %h want ffffff80", wb_data_out);
    end
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL lb_stall_cnt got %0d want 3", stall_cycles);
    end
    set_op(op_imm, 3'b000, 32'h0);
    data_resp = 1'b0;
  endtask

  task automatic test_store_byte();
    set_op(op_store, 3'b000, 32'h0000_2002);
    rs2_in = 32'h0000_00AB;
    mem_byte_enable_in = 4'b0100;
    PC_in = 32'h0000_0040;
    br_en_in = 1'b1;
    data_resp = 1'b1;
    #1;
    checks++;
    if (data_write !== 1'b1 || data_read !== 1'b0 ||
        data_wdata !== 32'h00AB_0000 || data_mbe !== 4'b0100 ||
        MA_stall !== 1'b0 || data_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL sb_req wr=%b rd=%b wd=%h mbe=%b st=%b a=%h",
               data_write, data_read, data_wdata, data_mbe,
               MA_stall, data_addr);
    end
    step();
    checks++;
    if (wb_data_out !== 32'h0000_2002 || PC_out !== 32'h0000_0040 ||
        br_en_out !== 1'b1 || ctrl_word_out.opcode !== op_store) begin
      errors++;
      $display("FAIL sb_wb wb=%h pc=%h br=%b want 2002 40 1",
               wb_data_out, PC_out, br_en_out);
    end
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL sb_stall_cnt got %0d want 3", stall_cycles);
    end
    br_en_in = 1'b0;
    mem_byte_enable_in = 4'b0000;
  endtask

  task automatic test_halfword();
    data_rdata = 32'hF00D_1234;
    data_resp  = 1'b1;
    set_op(op_load, 3'b101, 32'h0000_3002);
    #1;
    checks++;
    if (data_mbe !== 4'b0000 || data_write !== 1'b0) begin
      errors++;
      $display("FAIL lhu_mbe mbe=%b wr=%b want 0000 0",
               data_mbe, data_write);
    end
    step();
    checks++;
    if (wb_data_out !== 32'h0000_F00D) begin
      errors++;
      $display("FAIL lhu got %h want 0000f00d", wb_data_out);
    end
    set_op(op_load, 3'b001, 32'h0000_3002);
    step();
    checks++;
    if (wb_data_out !== 32'hFFFF_F00D) begin
      errors++;
      $display("FAIL lh got %h want fffff00d", wb_data_out);
    end
    data_rdata = 32'h80FF_1234;
    set_op(op_load, 3'b001, 32'h0000_3003);
    step();
    checks++;
    if (wb_data_out !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lh_off3 got %h want 00000080", wb_data_out);
    end
    set_op(op_load, 3'b100, 32'h0000_3001);
    step();
    checks++;
    if (wb_data_out !== 32'h0000_0012) begin
      errors++;
      $display("FAIL lbu got %h want 00000012", wb_data_out);
    end
    set_op(op_imm, 3'b000, 32'h0);
    data_resp = 1'b0;
  endtask

  task automatic test_if_stall_hold();
    logic [31:0] prev;
    prev = wb_data_out;
    step();
    prev = wb_data_out;
    set_op(op_load, 3'b010, 32'h0000_4000);
    data_rdata = 32'hCAFE_BABE;
    data_resp  = 1'b1;
    IF_stall   = 1'b1;
    step();
    data_rdata = 32'h1111_1111;
    data_resp  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_read !== 1'b0 || MA_stall !== 1'b0 ||
          wb_data_out !== prev) begin
        errors++;
        $display("FAIL hold%0d rd=%b st=%b wb=%h want 0 0 %h",
                 i, data_read, MA_stall, wb_data_out, prev);
      end
      step();
    end
    IF_stall = 1'b0;
    #1;
    checks++;
    if (data_read !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_rd got %b want 0", data_read);
    end
    step();
    checks++;
    if (wb_data_out !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL hold_data got %h want cafebabe", wb_data_out);
    end
    set_op(op_imm, 3'b000, 32'h0);
  endtask

  task automatic test_non_mem();
    set_op(op_reg, 3'b000, 32'h1234_5678);
    data_resp = 1'b1;
    #1;
    checks++;
    if (data_read !== 1'b0 || data_write !== 1'b0 ||
        MA_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_req rd=%b wr=%b st=%b want 0 0 0",
               data_read, data_write, MA_stall);
    end
    step();
    data_resp = 1'b0;
    checks++;
    if (wb_data_out !== 32'h1234_5678 || stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL alu_wb wb=%h sc=%0d want 12345678 3",
               wb_data_out, stall_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_op(op_load, 3'b010, 32'h0000_5000);
    data_resp = 1'b0;
    step(); step();
    checks++;
    if (stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL wait_cnt got %0d want 5", stall_cycles);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_read !== 1'b0 || MA_stall !== 1'b0 ||
        wb_data_out !== 32'h0 || stall_cycles !== 16'h0 ||
        PC_out !== 32'h0 || instruction_out !== 32'h0 ||
        br_en_out !== 1'b0 || ctrl_word_out !== '0) begin
      errors++;
      $display("FAIL rst_async rd=%b st=%b wb=%h sc=%0d pc=%h",
               data_read, MA_stall, wb_data_out, stall_cycles, PC_out);
    end
    step();
    rst = 1'b1;
    set_op(op_load, 3'b010, 32'h0000_6000);
    data_rdata = 32'h5555_AAAA;
    data_resp  = 1'b1;
    IF_stall   = 1'b1;
    step();
    data_resp = 1'b0;
    #1;
    checks++;
    if (data_read !== 1'b0) begin
      errors++;
      $display("FAIL enter_hold rd=%b want 0", data_read);
    end
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (data_read !== 1'b1 || MA_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_to_req rd=%b st=%b want 1 1",
               data_read, MA_stall);
    end
    IF_stall = 1'b0;
    set_op(op_imm, 3'b000, 32'h0);
    step();
  endtask

  initial begin
    test_reset();
    test_load_wait();
    test_store_byte();
    test_halfword();
    test_if_stall_hold();
    test_non_mem();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
